// File: rtl/layer0_sched_pkg.sv
// Shared types and default geometry for the layer-0 band scheduler.
// Bands overlap by OVERLAP rows so each 3x3 conv band carries its halo.
package layer0_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ROW_BEATS = 416;
  localparam int BAND_ROWS = 9;
  localparam int OVERLAP   = 2;
  localparam int LAST_ROWS = 3;
  localparam int NUM_BANDS = 60;
  localparam int ADDR_W    = 24;

  function automatic int band_beats(input int rows, input int row_beats);
    return rows * row_beats;
  endfunction

  localparam int STRIDE = band_beats(BAND_ROWS - OVERLAP, ROW_BEATS);
  localparam int NB     = band_beats(BAND_ROWS, ROW_BEATS);
  localparam int LB     = band_beats(LAST_ROWS, ROW_BEATS);

endpackage

// File: rtl/layer0_band_beat_chk.sv
// Counts accepted feature beats of the current band and flags the band end
// plus any length or out-of-band protocol violation as single-cycle pulses.
module layer0_band_beat_chk (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic        active,
  input  logic [15:0] cmd_beats,
  input  logic        beat_valid,
  input  logic        beat_ready,
  input  logic        beat_last,
  output logic        band_done,
  output logic        err
);

  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;
  logic        fire;
  logic        at_end;

  assign fire      = beat_valid && beat_ready;
  assign at_end    = (cnt_reg == cmd_beats - 16'd1);
  assign band_done = fire && active && beat_last;
  // Outside WAIT any beat is a protocol error; inside, last must coincide with the final count.
  assign err       = fire && (!active || (beat_last != at_end));

  always_comb begin
    cnt_next = cnt_reg;
    if (band_done) begin
      cnt_next = 16'd0;
    end else if (fire && active) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cnt_reg <= 16'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/layer0_band_scheduler.sv
// Issues one read command per overlapping row band to the feature TX path,
// waits for each band's final beat and pulses layer_done after the last band.
module layer0_band_scheduler #(
  parameter int ROW_BEATS = layer0_sched_pkg::ROW_BEATS,
  parameter int BAND_ROWS = layer0_sched_pkg::BAND_ROWS,
  parameter int OVERLAP   = layer0_sched_pkg::OVERLAP,
  parameter int LAST_ROWS = layer0_sched_pkg::LAST_ROWS,
  parameter int NUM_BANDS = layer0_sched_pkg::NUM_BANDS,
  parameter int ADDR_W    = layer0_sched_pkg::ADDR_W
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [15:0]       cmd_beats,
  output logic              cmd_last_band,
  input  logic              beat_valid,
  input  logic              beat_ready,
  input  logic              beat_last,
  output logic [7:0]        tx_cnt,
  output logic              busy,
  output logic              layer_done,
  output logic              len_err
);
  import layer0_sched_pkg::*;

  localparam logic [ADDR_W-1:0] STRIDE_ADDR =
    ADDR_W'(band_beats(BAND_ROWS - OVERLAP, ROW_BEATS));
  localparam logic [15:0] NORM_BEATS = 16'(band_beats(BAND_ROWS, ROW_BEATS));
  localparam logic [15:0] LAST_BEATS = 16'(band_beats(LAST_ROWS, ROW_BEATS));
  localparam logic [7:0]  LAST_IDX   = 8'(NUM_BANDS - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [7:0]        tx_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       beats_reg;
  logic              err_reg;
  logic              start_ok;
  logic              in_wait;
  logic              last_band;
  logic              band_done;
  logic              chk_err;

  assign start_ok  = (state_reg == IDLE) && start;
  assign in_wait   = (state_reg == WAIT);
  assign last_band = (tx_cnt_reg == LAST_IDX);

  layer0_band_beat_chk u_beat_chk (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .active     (in_wait),
    .cmd_beats  (beats_reg),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_last  (beat_last),
    .band_done  (band_done),
    .err        (chk_err)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   if (cmd_ready) state_next = WAIT;
      WAIT:    if (band_done) state_next = last_band ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid  = 1'b0;
    busy       = 1'b1;
    layer_done = 1'b0;
    case (state_reg)
      IDLE:    busy = 1'b0;
      ISSUE:   cmd_valid = 1'b1;
      DONE:    layer_done = 1'b1;
      default: ;
    endcase
  end

  // Command fields are registered when a band is armed so they stay stable while stalled.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      tx_cnt_reg <= 8'd0;
      addr_reg   <= '0;
      beats_reg  <= 16'd0;
      err_reg    <= 1'b0;
    end else begin
      if (start_ok) begin
        tx_cnt_reg <= 8'd0;
        addr_reg   <= '0;
        beats_reg  <= (LAST_IDX == 8'd0) ? LAST_BEATS : NORM_BEATS;
      end else if (in_wait && band_done && !last_band) begin
        tx_cnt_reg <= tx_cnt_reg + 8'd1;
        addr_reg   <= addr_reg + STRIDE_ADDR;
        beats_reg  <= (tx_cnt_reg + 8'd1 == LAST_IDX) ? LAST_BEATS : NORM_BEATS;
      end
      if (chk_err) begin
        err_reg <= 1'b1;
      end else if (start_ok) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign cmd_addr      = addr_reg;
  assign cmd_beats     = beats_reg;
  assign cmd_last_band = cmd_valid && last_band;
  assign tx_cnt        = tx_cnt_reg;
  assign len_err       = err_reg;

endmodule

// File: tb/tb_layer0_band_scheduler.sv
// Directed/randomized bench: a default-geometry instance for band-level checks and
// a short-row instance (ROW_BEATS=8) so a full 60-band layer fits the cycle budget.
module tb_layer0_band_scheduler;

  localparam int SMALL_RB = 8;

  logic sclk = 1'b0;
  logic s_rst_n = 1'b0;
  always #5 sclk = ~sclk;

  logic        start [2];
  logic        cmd_ready [2];
  logic        beat_valid [2];
  logic        beat_ready [2];
  logic        beat_last [2];
  logic        cmd_valid [2];
  logic        cmd_last_band [2];
  logic        busy [2];
  logic        layer_done [2];
  logic        len_err [2];
  logic [23:0] cmd_addr [2];
  logic [15:0] cmd_beats [2];
  logic [7:0]  tx_cnt [2];

  int n_cmp = 0;
  int n_bad = 0;
  int done_pulses = 0;

  layer0_band_scheduler dut_full (
    .sclk(sclk), .s_rst_n(s_rst_n), .start(start[0]),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_addr(cmd_addr[0]),
    .cmd_beats(cmd_beats[0]), .cmd_last_band(cmd_last_band[0]),
    .beat_valid(beat_valid[0]), .beat_ready(beat_ready[0]), .beat_last(beat_last[0]),
    .tx_cnt(tx_cnt[0]), .busy(busy[0]), .layer_done(layer_done[0]), .len_err(len_err[0])
  );

  layer0_band_scheduler #(.ROW_BEATS(SMALL_RB)) dut_small (
    .sclk(sclk), .s_rst_n(s_rst_n), .start(start[1]),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_addr(cmd_addr[1]),
    .cmd_beats(cmd_beats[1]), .cmd_last_band(cmd_last_band[1]),
    .beat_valid(beat_valid[1]), .beat_ready(beat_ready[1]), .beat_last(beat_last[1]),
    .tx_cnt(tx_cnt[1]), .busy(busy[1]), .layer_done(layer_done[1]), .len_err(len_err[1])
  );

  always @(posedge sclk) if (layer_done[1] === 1'b1) done_pulses++;

  // Reference geometry straight from the band rules.
  function automatic int row_beats(input int sel);
    return (sel == 0) ? 416 : SMALL_RB;
  endfunction
  function automatic int exp_beats(input int sel, input int k);
    return ((k == 59) ? 3 : 9) * row_beats(sel);
  endfunction
  function automatic int exp_addr(input int sel, input int k);
    return k * (9 - 2) * row_beats(sel);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic issue_cmd(input int sel, input int k, input bit stall);
    int guard;
    guard = 0;
    while (cmd_valid[sel] !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    chk("cmd_valid_wait", cmd_valid[sel], 1);
    chk("cmd_addr", cmd_addr[sel], exp_addr(sel, k));
    chk("cmd_beats", cmd_beats[sel], exp_beats(sel, k));
    chk("cmd_last_band", cmd_last_band[sel], k == 59);
    chk("tx_cnt", tx_cnt[sel], k);
    cmd_ready[sel] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cmd_ready[sel] !== 1'b1) begin
      step();
      cmd_ready[sel] = 1'($urandom_range(0, 1));
    end
    step();
    cmd_ready[sel] = 1'b0;
    chk("cmd_valid_drop", cmd_valid[sel], 0);
  endtask

  task automatic send_beats(input int sel, input int total, input int last_at, input bit stall);
    for (int i = 1; i <= total; i++) begin
      bit bv;
      bit br;
      do begin
        bv = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        br = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        beat_valid[sel] = bv;
        beat_ready[sel] = br;
        beat_last[sel]  = (i == last_at);
        step();
      end while (!(bv && br));
    end
    beat_valid[sel] = 1'b0;
    beat_ready[sel] = 1'b0;
    beat_last[sel]  = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; cmd_ready[s] = 1'b0;
      beat_valid[s] = 1'b0; beat_ready[s] = 1'b0; beat_last[s] = 1'b0;
    end
    s_rst_n = 1'b0;
    step(); step();
    s_rst_n = 1'b1;
    step();

    // Reset state on both instances
    for (int s = 0; s < 2; s++) begin
      chk("rst_cmd_valid", cmd_valid[s], 0);
      chk("rst_cmd_addr", cmd_addr[s], 0);
      chk("rst_cmd_beats", cmd_beats[s], 0);
      chk("rst_last_band", cmd_last_band[s], 0);
      chk("rst_tx_cnt", tx_cnt[s], 0);
      chk("rst_busy", busy[s], 0);
      chk("rst_layer_done", layer_done[s], 0);
      chk("rst_len_err", len_err[s], 0);
    end

    // Beats while idle are protocol errors; the next start clears them
    for (int i = 0; i < 8; i++) begin
      beat_valid[0] = 1'($urandom_range(0, 1));
      beat_ready[0] = 1'($urandom_range(0, 1));
      step();
    end
    beat_valid[0] = 1'b1; beat_ready[0] = 1'b1;
    step();
    beat_valid[0] = 1'b0; beat_ready[0] = 1'b0;
    chk("idle_beat_err", len_err[0], 1);
    chk("idle_busy", busy[0], 0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    chk("start_clears_err", len_err[0], 0);
    chk("start_busy", busy[0], 1);
    chk("start_cmd_valid", cmd_valid[0], 1);

    // Command held stable under cmd_ready stall; start while busy ignored
    for (int i = 0; i < 10; i++) begin
      start[0] = (i == 4);
      step();
      chk("stall_cmd_valid", cmd_valid[0], 1);
      chk("stall_cmd_addr", cmd_addr[0], 0);
      chk("stall_cmd_beats", cmd_beats[0], 3744);
      chk("stall_tx_cnt", tx_cnt[0], 0);
      chk("stall_len_err", len_err[0], 0);
    end
    start[0] = 1'b0;

    // Band 0 with the exact beat count, band 1 follows one cycle after the last beat
    issue_cmd(0, 0, 1'b0);
    send_beats(0, 3744, 3744, 1'b0);
    chk("band1_valid_next", cmd_valid[0], 1);
    chk("band1_tx_cnt", tx_cnt[0], 1);
    chk("band1_addr", cmd_addr[0], 2912);
    chk("band0_len_ok", len_err[0], 0);

    // Early last on beat 100 of band 1: error but the band still advances
    issue_cmd(0, 1, 1'b0);
    send_beats(0, 100, 100, 1'b0);
    chk("early_last_err", len_err[0], 1);
    chk("early_last_adv", tx_cnt[0], 2);
    chk("early_last_valid", cmd_valid[0], 1);

    // Run to band 5 and assert reset partway through it
    for (int k = 2; k < 5; k++) begin
      issue_cmd(0, k, 1'b0);
      send_beats(0, 3744, 3744, 1'b0);
    end
    issue_cmd(0, 5, 1'b0);
    send_beats(0, 50, 0, 1'b0);
    #2 s_rst_n = 1'b0;
    #1;
    chk("arst_busy", busy[0], 0);
    chk("arst_tx_cnt", tx_cnt[0], 0);
    chk("arst_addr", cmd_addr[0], 0);
    chk("arst_beats", cmd_beats[0], 0);
    chk("arst_len_err", len_err[0], 0);
    chk("arst_cmd_valid", cmd_valid[0], 0);
    step();
    s_rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy[0], 0);
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    issue_cmd(0, 0, 1'b0);

    // Overrun: the 3744th beat without last is an error, counting continues
    send_beats(0, 3743, 0, 1'b0);
    chk("pre_overrun_ok", len_err[0], 0);
    send_beats(0, 1, 0, 1'b0);
    chk("overrun_err", len_err[0], 1);
    chk("overrun_waiting", cmd_valid[0], 0);
    chk("overrun_busy", busy[0], 1);
    send_beats(0, 1, 1, 1'b0);
    chk("overrun_adv", tx_cnt[0], 1);
    chk("overrun_next_valid", cmd_valid[0], 1);

    // Full layer on the short-row instance with random stalls
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    for (int k = 0; k < 60; k++) begin
      issue_cmd(1, k, 1'b1);
      send_beats(1, exp_beats(1, k), exp_beats(1, k), 1'b1);
      if (k < 59) chk("layer_band_err", len_err[1], 0);
    end
    chk("layer_done_pulse", layer_done[1], 1);
    step();
    chk("layer_done_drop", layer_done[1], 0);
    chk("layer_idle", busy[1], 0);
    chk("layer_tx_cnt_hold", tx_cnt[1], 59);
    chk("layer_len_err", len_err[1], 0);
    chk("layer_no_cmd", cmd_valid[1], 0);
    chk("layer_done_count", done_pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
